cfg_frame_sequencer: RTL and testbench



---
 rtl/cfg_seq_pkg.sv | 33 +++
 rtl/cfg_strobe_decode.sv | 36 +++
 rtl/cfg_frame_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cfg_frame_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// Shared types and header field layout for the column configuration sequencer.
package cfg_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    STROBE  = 3'd2,
    GAP     = 3'd3,
    DISCARD = 3'd4
  } seq_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 24;
  localparam int COL_MSB  = 23;
  localparam int COL_LSB  = 16;
  localparam int FRM_MSB  = 15;
  localparam int FRM_LSB  = 8;

  function automatic logic [7:0] hdr_sync(input logic [31:0] w);
    return w[SYNC_MSB:SYNC_LSB];
  endfunction

  function automatic logic [7:0] hdr_col(input logic [31:0] w);
    return w[COL_MSB:COL_LSB];
  endfunction

  function automatic logic [7:0] hdr_frame(input logic [31:0] w);
    return w[FRM_MSB:FRM_LSB];
  endfunction

endpackage

// File: rtl/cfg_strobe_decode.sv
// Registered one-hot decoder: (column, frame, enable) -> flattened FrameStrobe vector.
module cfg_strobe_decode #(
  parameter int NumColumns      = 4,
  parameter int MaxFramesPerCol = 20,
  parameter int ColW            = 2,
  parameter int FrmW            = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  en_i,
  input  logic [ColW-1:0]                       col_i,
  input  logic [FrmW-1:0]                       frame_i,
  output logic [NumColumns*MaxFramesPerCol-1:0] strobe_o
);

  localparam int NumStrb = NumColumns * MaxFramesPerCol;
  localparam int IdxW    = (NumStrb > 1) ? $clog2(NumStrb) : 1;

  logic [IdxW-1:0]    idx;
  logic [NumStrb-1:0] strobe_q;

  assign idx = IdxW'(col_i) * IdxW'(MaxFramesPerCol) + IdxW'(frame_i);

  // Cleared every cycle so at most one bit can ever be high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      if (en_i) strobe_q[idx] <= 1'b1;
    end
  end

  assign strobe_o = strobe_q;

endmodule

// File: rtl/cfg_frame_sequencer.sv
// Assembles one configuration frame from a 32-bit word stream and pulses the
// addressed column/frame strobe so the tiles of the column latch it.
module cfg_frame_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 8,
  parameter int NumColumns      = 4,
  parameter int StrobeCycles    = 2
) (
  input  logic                                  UserCLK,
  input  logic                                  resetn,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [31:0]                           s_data,
  output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  input  logic                                  err_clear,
  output logic [15:0]                           frames_done
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int ColW = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int FrmW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
  localparam int CntW = 4;

  seq_state_e                         state_q;
  logic [RowW-1:0]                    row_cnt_q;
  logic [CntW-1:0]                    strb_cnt_q;
  logic [ColW-1:0]                    col_q;
  logic [FrmW-1:0]                    frame_q;
  logic [NumRows*FrameBitsPerRow-1:0] frame_data_q;
  logic                               s_ready_q;
  logic                               busy_q;
  logic                               err_q;
  logic [15:0]                        frames_done_q;

  logic accept;
  logic sync_ok;
  logic range_ok;
  logic hdr_ok;
  logic last_row;
  logic strobe_last;
  logic err_set;
  logic strobe_en;

  assign accept      = s_valid && s_ready_q;
  assign sync_ok     = (hdr_sync(s_data) == SYNC_BYTE);
  assign range_ok    = (int'(hdr_col(s_data)) < NumColumns) &&
                       (int'(hdr_frame(s_data)) < MaxFramesPerCol);
  assign hdr_ok      = sync_ok && range_ok;
  assign last_row    = (row_cnt_q == RowW'(NumRows - 1));
  assign strobe_last = (strb_cnt_q == CntW'(StrobeCycles - 1));
  assign err_set     = accept && (state_q == IDLE) && !hdr_ok;

  // Strobe is asserted from the edge that accepts the final row, so the
  // decoder register goes high in the first STROBE cycle.
  assign strobe_en = ((state_q == LOAD) && accept && last_row) ||
                     ((state_q == STROBE) && !strobe_last);

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      row_cnt_q     <= '0;
      strb_cnt_q    <= '0;
      col_q         <= '0;
      frame_q       <= '0;
      frame_data_q  <= '0;
      s_ready_q     <= 1'b0;
      busy_q        <= 1'b0;
      frames_done_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          s_ready_q <= 1'b1;
          if (accept && sync_ok) begin
            row_cnt_q <= '0;
            busy_q    <= 1'b1;
            if (range_ok) begin
              col_q   <= ColW'(hdr_col(s_data));
              frame_q <= FrmW'(hdr_frame(s_data));
              state_q <= LOAD;
            end else begin
              state_q <= DISCARD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            frame_data_q[int'(row_cnt_q)*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_row) begin
              state_q       <= STROBE;
              s_ready_q     <= 1'b0;
              strb_cnt_q    <= '0;
              frames_done_q <= frames_done_q + 16'd1;
            end
          end
        end
        STROBE: begin
          strb_cnt_q <= strb_cnt_q + 1'b1;
          if (strobe_last) state_q <= GAP;
        end
        GAP: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        DISCARD: begin
          if (accept) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_row) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          s_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // A new error event takes priority over a simultaneous clear.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (err_clear) begin
      err_q <= 1'b0;
    end
  end

  cfg_strobe_decode #(
    .NumColumns      (NumColumns),
    .MaxFramesPerCol (MaxFramesPerCol),
    .ColW            (ColW),
    .FrmW            (FrmW)
  ) u_strobe_decode (
    .clk_i    (UserCLK),
    .rst_ni   (resetn),
    .en_i     (strobe_en),
    .col_i    (col_q),
    .frame_i  (frame_q),
    .strobe_o (FrameStrobe)
  );

  assign s_ready     = s_ready_q;
  assign FrameData   = frame_data_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign frames_done = frames_done_q;

endmodule

// File: tb/tb_cfg_frame_sequencer.sv
// Directed bench for cfg_frame_sequencer with hand-computed expected values.
module tb_cfg_frame_sequencer;

  logic         UserCLK;
  logic         resetn;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [255:0] FrameData;
  logic [79:0]  FrameStrobe;
  logic         busy;
  logic         err;
  logic         err_clear;
  logic [15:0]  frames_done;

  int total;
  int bad;
  int strobe_hi_cycles;
  int multi_hot_cycles;
  int ready_in_strobe;

  cfg_frame_sequencer dut (
    .UserCLK     (UserCLK),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .FrameData   (FrameData),
    .FrameStrobe (FrameStrobe),
    .busy        (busy),
    .err         (err),
    .err_clear   (err_clear),
    .frames_done (frames_done)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  // Continuous strobe sanity monitor, sampled on the falling edge.
  always @(negedge UserCLK) begin
    if (FrameStrobe != '0) strobe_hi_cycles++;
    if ($countones(FrameStrobe) > 1) multi_hot_cycles++;
    if ((FrameStrobe != '0) && s_ready) ready_in_strobe++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge UserCLK);
      #1;
    end
  endtask

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && n < 50) begin
      tick(1);
      n++;
    end
    chk("push_ready", {127'd0, s_ready}, 128'd1);
    tick(1);
    s_valid = 1'b0;
  endtask

  task automatic push_rows(input logic [31:0] base, input bit gaps);
    for (int r = 0; r < 8; r++) begin
      if (gaps) tick($urandom_range(0, 2));
      push(base + 32'(r));
    end
  endtask

  task automatic check_rows(input string tag, input logic [31:0] base);
    for (int r = 0; r < 8; r++)
      chk(tag, {96'd0, FrameData[r*32 +: 32]}, {96'd0, base + 32'(r)});
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
  endtask

  logic [79:0] one;
  int          hi_before;

  initial begin
    total = 0; bad = 0;
    strobe_hi_cycles = 0; multi_hot_cycles = 0; ready_in_strobe = 0;
    one       = 80'd1;
    resetn    = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    err_clear = 1'b0;

    // Reset state
    #12;
    chk("rst_ready",  {127'd0, s_ready}, 128'd0);
    chk("rst_strobe", {48'd0, FrameStrobe}, 128'd0);
    chk("rst_data",   FrameData[127:0], 128'd0);
    chk("rst_busy",   {127'd0, busy}, 128'd0);
    chk("rst_err",    {127'd0, err}, 128'd0);
    chk("rst_frames", {112'd0, frames_done}, 128'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    tick(1);
    chk("ready_after_rst", {127'd0, s_ready}, 128'd1);

    // Basic frame: column 1, frame 5 -> bit 25
    push(32'hFA01_0500);
    chk("t1_busy", {127'd0, busy}, 128'd1);
    push_rows(32'h1000_0000, 1'b0);
    chk("t1_strobe0", {48'd0, FrameStrobe}, {48'd0, one << 25});
    chk("t1_ready0",  {127'd0, s_ready}, 128'd0);
    chk("t1_frames",  {112'd0, frames_done}, 128'd1);
    check_rows("t1_row", 32'h1000_0000);
    tick(1);
    chk("t1_strobe1", {48'd0, FrameStrobe}, {48'd0, one << 25});
    tick(1);
    chk("t1_gap_strobe", {48'd0, FrameStrobe}, 128'd0);
    chk("t1_gap_ready",  {127'd0, s_ready}, 128'd0);
    tick(1);
    chk("t1_ready_back", {127'd0, s_ready}, 128'd1);
    chk("t1_idle_busy",  {127'd0, busy}, 128'd0);

    // Bad sync is dropped, next header loads normally
    push(32'h1200_0000);
    chk("t2_err",   {127'd0, err}, 128'd1);
    chk("t2_busy",  {127'd0, busy}, 128'd0);
    chk("t2_ready", {127'd0, s_ready}, 128'd1);
    pulse_clear();
    chk("t2_err_cleared", {127'd0, err}, 128'd0);
    push(32'hFA00_0300);
    push_rows(32'hB000_0000, 1'b0);
    chk("t2_strobe", {48'd0, FrameStrobe}, {48'd0, one << 3});
    chk("t2_frames", {112'd0, frames_done}, 128'd2);
    check_rows("t2_row", 32'hB000_0000);
    tick(3);

    // Column out of range -> discard
    hi_before = strobe_hi_cycles;
    push(32'hFA04_0000);
    chk("t3_err",  {127'd0, err}, 128'd1);
    chk("t3_busy", {127'd0, busy}, 128'd1);
    push_rows(32'hDEAD_0000, 1'b0);
    chk("t3_idle", {127'd0, busy}, 128'd0);
    tick(3);
    chk("t3_no_strobe", 128'(strobe_hi_cycles - hi_before), 128'd0);
    check_rows("t3_row_kept", 32'hB000_0000);
    chk("t3_frames", {112'd0, frames_done}, 128'd2);

    // Frame 20 is also out of range
    pulse_clear();
    push(32'hFA00_1400);
    chk("t3b_err", {127'd0, err}, 128'd1);
    push_rows(32'hEEEE_0000, 1'b0);
    tick(3);
    chk("t3b_no_strobe", 128'(strobe_hi_cycles - hi_before), 128'd0);
    check_rows("t3b_row_kept", 32'hB000_0000);

    // Gapped valid, column 3 frame 19 -> bit 79
    push(32'hFA03_1300);
    push_rows(32'hC300_0000, 1'b1);
    chk("t4_strobe0", {48'd0, FrameStrobe}, {48'd0, one << 79});
    chk("t4_ready0",  {127'd0, s_ready}, 128'd0);
    check_rows("t4_row", 32'hC300_0000);
    tick(1);
    chk("t4_strobe1", {48'd0, FrameStrobe}, {48'd0, one << 79});
    chk("t4_ready1",  {127'd0, s_ready}, 128'd0);
    tick(1);
    chk("t4_gap_ready", {127'd0, s_ready}, 128'd0);
    chk("t4_frames",    {112'd0, frames_done}, 128'd3);
    tick(1);

    // err_clear vs simultaneous error event
    pulse_clear();
    chk("t5_err_pre", {127'd0, err}, 128'd0);
    err_clear = 1'b1;
    push(32'h5500_0000);
    err_clear = 1'b0;
    chk("t5_set_wins", {127'd0, err}, 128'd1);
    pulse_clear();
    chk("t5_clear", {127'd0, err}, 128'd0);

    // Reset during the second strobe cycle
    push(32'hFA02_0000);
    push_rows(32'h2200_0000, 1'b0);
    tick(1);
    chk("t6_strobe1", {48'd0, FrameStrobe}, {48'd0, one << 40});
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_strobe_drop", {48'd0, FrameStrobe}, 128'd0);
    chk("t6_data_lo",     FrameData[127:0], 128'd0);
    chk("t6_data_hi",     FrameData[255:128], 128'd0);
    chk("t6_frames",      {112'd0, frames_done}, 128'd0);
    chk("t6_ready",       {127'd0, s_ready}, 128'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    tick(1);
    push(32'hFA01_0000);
    push_rows(32'h3300_0000, 1'b0);
    chk("t6_post_strobe", {48'd0, FrameStrobe}, {48'd0, one << 20});
    chk("t6_post_frames", {112'd0, frames_done}, 128'd1);
    check_rows("t6_post_row", 32'h3300_0000);
    tick(4);

    chk("mon_multi_hot",       128'(multi_hot_cycles), 128'd0);
    chk("mon_ready_in_strobe", 128'(ready_in_strobe), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
